// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial N-bit adder/subtractor with valid/ready handshakes
// Processes DIGIT bits per clock, LSB chunk first, through one DIGIT-bit slice and a carry/borrow register.

module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_mode;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_ovf;

  logic [IW-1:0]    w_base;
  logic [DIGIT-1:0] w_ak;
  logic [DIGIT-1:0] w_bk;
  logic [DIGIT:0]   w_sum;
  logic             w_last;
  logic             w_a_msb;
  logic             w_b_msb;
  logic             w_ovf;

  assign w_base  = IW'(32'(r_cnt) * DIGIT);
  assign w_ak    = r_a[w_base +: DIGIT];
  assign w_bk    = r_b[w_base +: DIGIT];
  assign w_last  = (r_cnt == CW'(NCHUNK - 1));
  assign w_a_msb = r_a[WIDTH-1];
  assign w_b_msb = r_b[WIDTH-1];

  // The top bit of the (DIGIT+1)-bit result is the carry for add and the borrow for sub.
  always_comb begin
    w_sum = '0;
    if (r_mode) begin
      w_sum = {1'b0, w_ak} + {1'b0, w_bk} + {{DIGIT{1'b0}}, r_c};
    end else begin
      w_sum = {1'b0, w_ak} - {1'b0, w_bk} - {{DIGIT{1'b0}}, r_c};
    end
  end

  // Only meaningful on the last chunk, where w_sum[DIGIT-1] is the result MSB.
  assign w_ovf = (r_mode ? ~(w_a_msb ^ w_b_msb) : (w_a_msb ^ w_b_msb))
               & (w_sum[DIGIT-1] ^ w_a_msb);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_mode <= 1'b0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_d    <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a    <= a;
            r_b    <= b;
            r_mode <= mode;
            r_c    <= bin;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_d[w_base +: DIGIT] <= w_sum[DIGIT-1:0];
          r_c                  <= w_sum[DIGIT];
          r_cnt                <= r_cnt + CW'(1);
          if (w_last) begin
            r_bout <= w_sum[DIGIT];
            r_ovf  <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign d    = r_d;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed bench for serial_addsub
// Main instance uses DIGIT=2; a side bank of four instances sweeps DIGIT over 1, 2, 4, 8.

module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] d;
  logic       bout;
  logic       ovf;

  logic       s_in_valid;
  logic [7:0] s_a;
  logic [7:0] s_b;
  logic       s_bin;
  logic       s_mode;
  logic       s_out_ready;
  logic       sw_in_ready  [4];
  logic       sw_out_valid [4];
  logic [7:0] sw_d         [4];
  logic       sw_bout      [4];
  logic       sw_ovf       [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .ovf(ovf)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    serial_addsub #(.WIDTH(8), .DIGIT(1 << g)) u_sw (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(sw_in_ready[g]),
      .a(s_a), .b(s_b), .bin(s_bin), .mode(s_mode),
      .out_valid(sw_out_valid[g]), .out_ready(s_out_ready),
      .d(sw_d[g]), .bout(sw_bout[g]), .ovf(sw_ovf[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_d got %h want 00", d); end
    n_vec++; if (bout !== 1'b0) begin n_err++; $display("FAIL reset_bout got %b want 0", bout); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
  endtask

  task automatic run_op(input string nm, input logic m, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ibin, input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s idle_in_ready got %b want 1", nm, in_ready); end
    mode = m; a = ia; b = ib; bin = ibin; in_valid = 1'b1;
    step();
    in_valid = 1'b0; a = ~ia; b = ~ib; bin = ~ibin; mode = ~m;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL %s run_in_ready got %b want 0", nm, in_ready); end
      step();
      lat++;
    end
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL %s latency got %0d want 4", nm, lat); end
    n_vec++; if (d !== ed) begin n_err++; $display("FAIL %s d got %h want %h", nm, d, ed); end
    n_vec++; if (bout !== eb) begin n_err++; $display("FAIL %s bout got %b want %b", nm, bout, eb); end
    n_vec++; if (ovf !== eo) begin n_err++; $display("FAIL %s ovf got %b want %b", nm, ovf, eo); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s post_out_valid got %b want 0", nm, out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s post_in_ready got %b want 1", nm, in_ready); end
  endtask

  task automatic test_arith();
    run_op("sub_zero",   1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("sub_bin",    1'b0, 8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0);
    run_op("sub_neg",    1'b0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op("sub_ovf",    1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("add_carry",  1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_ovf",    1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    mode = 1'b1; a = 8'h60; b = 8'h30; bin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin step(); lat++; end
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL bp_latency got %0d want 4", lat); end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 8'hFF; b = 8'hFF; bin = 1'b0; mode = 1'b0;
      step();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid cyc %0d got %b want 1", i, out_valid); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
      n_vec++; if (d !== 8'h91) begin n_err++; $display("FAIL bp_d cyc %0d got %h want 91", i, d); end
      n_vec++; if (bout !== 1'b0) begin n_err++; $display("FAIL bp_bout cyc %0d got %b want 0", i, bout); end
      n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL bp_ovf cyc %0d got %b want 1", i, ovf); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    n_vec++; if (d !== 8'h91) begin n_err++; $display("FAIL bp_hold_d got %h want 91", d); end
    run_op("bp_next", 1'b0, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_op();
    mode = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL midrst_d got %h want 00", d); end
    n_vec++; if (bout !== 1'b0) begin n_err++; $display("FAIL midrst_bout got %b want 0", bout); end
    run_op("after_rst", 1'b0, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
  endtask

  task automatic sweep_one(input logic m, input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
    logic [8:0] r;
    logic [7:0] ed;
    logic       eb;
    logic       eo;
    int         lat [4];
    if (m) r = {1'b0, ia} + {1'b0, ib} + {8'h00, ibin};
    else   r = {1'b0, ia} - {1'b0, ib} - {8'h00, ibin};
    ed = r[7:0];
    eb = r[8];
    if (m) eo = (ia[7] == ib[7]) && (ed[7] != ia[7]);
    else   eo = (ia[7] != ib[7]) && (ed[7] != ia[7]);
    s_mode = m; s_a = ia; s_b = ib; s_bin = ibin; s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    for (int g = 0; g < 4; g++) lat[g] = -1;
    for (int cyc = 0; cyc <= 9; cyc++) begin
      for (int g = 0; g < 4; g++) if (sw_out_valid[g] === 1'b1 && lat[g] < 0) lat[g] = cyc;
      if (cyc < 9) step();
    end
    for (int g = 0; g < 4; g++) begin
      n_vec++; if (lat[g] != (8 >> g)) begin n_err++; $display("FAIL sweep_lat digit=%0d got %0d want %0d", 1 << g, lat[g], 8 >> g); end
      n_vec++; if (sw_d[g] !== ed) begin n_err++; $display("FAIL sweep_d digit=%0d m=%b a=%h b=%h bin=%b got %h want %h", 1 << g, m, ia, ib, ibin, sw_d[g], ed); end
      n_vec++; if (sw_bout[g] !== eb) begin n_err++; $display("FAIL sweep_bout digit=%0d m=%b a=%h b=%h bin=%b got %b want %b", 1 << g, m, ia, ib, ibin, sw_bout[g], eb); end
      n_vec++; if (sw_ovf[g] !== eo) begin n_err++; $display("FAIL sweep_ovf digit=%0d m=%b a=%h b=%h bin=%b got %b want %b", 1 << g, m, ia, ib, ibin, sw_ovf[g], eo); end
    end
    s_out_ready = 1'b1;
    step();
    s_out_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      n_vec++; if (sw_in_ready[g] !== 1'b1) begin n_err++; $display("FAIL sweep_idle digit=%0d got %b want 1", 1 << g, sw_in_ready[g]); end
    end
  endtask

  task automatic test_sweep();
    sweep_one(1'b0, 8'h00, 8'h00, 1'b0);
    sweep_one(1'b0, 8'h00, 8'h00, 1'b1);
    sweep_one(1'b0, 8'h80, 8'h01, 1'b0);
    sweep_one(1'b0, 8'h7F, 8'h80, 1'b1);
    sweep_one(1'b1, 8'hFF, 8'hFF, 1'b1);
    sweep_one(1'b1, 8'h7F, 8'h00, 1'b1);
    sweep_one(1'b1, 8'h80, 8'h80, 1'b0);
    sweep_one(1'b1, 8'h55, 8'hAA, 1'b1);
    for (int i = 0; i < 40; i++) begin
      sweep_one(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; mode = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_bin = 1'b0; s_mode = 1'b0; s_out_ready = 1'b0;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_op();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
